// File: rtl/im_boot_loader.sv
// ---------------------------------------------------------------------------
// im_boot_loader
//
// Writer side of the CPU instruction memory. Receives a byte stream over a
// valid/ready handshake, assembles big-endian 32-bit words and writes them
// to consecutive word addresses starting at 0. The CPU is held in reset
// until the whole image has been received and its checksum verifies.
//
// The stream consists of:
//   count_hi, count_lo   16-bit word count N, big-endian
//   N x 4 data bytes     each word MSB first
//   checksum byte        chosen so that the 8-bit sum of all bytes is 0x00
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   in_valid      byte on in_data is valid
//   in_data       stream byte
//   in_ready      loader can accept a byte this cycle
//   im_we         instruction memory write strobe, one cycle per word
//   im_addr       instruction memory word address
//   im_din        instruction word to write
//   cpu_rst       reset to the CPU, high until the image is accepted
//   done          image loaded and verified (sticky until rst)
//   err           image rejected (sticky until rst)
//   words_loaded  number of words written so far
//
// state  | meaning
// -------+--------------------------------------------------------------
// HDR_HI | waiting for the high byte of the word count
// HDR_LO | waiting for the low byte of the word count
// DATA   | assembling and writing data words
// CSUM   | waiting for the checksum byte
// DONE   | image accepted, CPU released (terminal)
// ERR    | image rejected, CPU held in reset (terminal)
// ---------------------------------------------------------------------------
module im_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [15:0]       r_count;
  logic [1:0]        r_idx;
  logic [23:0]       r_asm;
  logic [7:0]        r_sum;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_rst;

  logic              w_accept;
  logic [15:0]       w_count_full;
  logic [7:0]        w_sum_next;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_last_byte;
  logic              w_word_done;

  assign w_accept     = in_valid & in_ready;
  // Full count is known in the HDR_LO cycle, before r_count[7:0] is loaded.
  assign w_count_full = {r_count[15:8], in_data};
  assign w_sum_next   = r_sum + in_data;
  assign w_words_inc  = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_byte  = (r_idx == 2'd3);
  assign w_word_done  = w_accept && (r_state == S_DATA) && w_last_byte;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR_HI;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_HI: if (w_accept) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_count_full > 16'(MAX_WORDS)) w_next = S_ERR;
          else if (w_count_full == 16'd0)    w_next = S_CSUM;
          else                               w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_done && (16'(w_words_inc) == r_count)) w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept) w_next = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Output logic. in_ready depends only on state and rst, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM: in_ready = ~rst;
      default:                            in_ready = 1'b0;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_asm     <= '0;
      r_sum     <= '0;
      r_words   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_sum <= w_sum_next;
        case (r_state)
          S_HDR_HI: r_count[15:8] <= in_data;
          S_HDR_LO: r_count[7:0]  <= in_data;
          S_DATA: begin
            r_asm <= {r_asm[15:0], in_data};
            r_idx <= r_idx + 2'd1;
            if (w_last_byte) begin
              r_din   <= {r_asm, in_data};
              r_addr  <= r_words[ADDR_W-1:0];
              r_we    <= 1'b1;
              r_words <= w_words_inc;
            end
          end
          default: ;
        endcase
      end
      // Status flips on the same edge that enters the terminal state.
      if (w_next == S_DONE) begin
        r_done    <= 1'b1;
        r_cpu_rst <= 1'b0;
      end
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign im_we        = r_we;
  assign im_addr      = r_addr;
  assign im_din       = r_din;
  assign cpu_rst      = r_cpu_rst;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_im_boot_loader.sv
module tb_im_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_din;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  im_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_din(im_din),
    .cpu_rst(cpu_rst), .done(done), .err(err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write monitor: records every write strobe into a memory image.
  logic [31:0]       mem [0:MAX_WORDS-1];
  int                wr_n = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       first_din;
  logic [ADDR_W-1:0] first_addr;
  int                wr_base = 0;

  always @(negedge clk) begin
    if (im_we) begin
      mem[im_addr] = im_din;
      if (wr_n == wr_base) begin
        first_addr = im_addr;
        first_din  = im_din;
      end
      last_addr = im_addr;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_base = wr_n;
  endtask

  logic [7:0] nom [0:10];
  logic [7:0] sum;
  logic [31:0] w;

  initial begin
    nom[0] = 8'h00; nom[1] = 8'h02; nom[2] = 8'h24; nom[3] = 8'h01;
    nom[4] = 8'h00; nom[5] = 8'h05; nom[6] = 8'h00; nom[7] = 8'h22;
    nom[8] = 8'h18; nom[9] = 8'h21; nom[10] = 8'h79;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #12;
    // Reset values
    check("rst_in_ready", in_ready, 0);
    check("rst_im_we", im_we, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_din", im_din, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_loaded, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Nominal stream at full rate
    wr_base = wr_n;
    for (int i = 0; i < 10; i++) send(nom[i], 0);
    check("nom_done_before_csum", done, 0);
    check("nom_cpu_rst_before_csum", cpu_rst, 1);
    send(nom[10], 0);
    check("nom_done", done, 1);
    check("nom_cpu_rst", cpu_rst, 0);
    check("nom_err", err, 0);
    check("nom_wr_count", wr_n - wr_base, 2);
    check("nom_first_addr", first_addr, 0);
    check("nom_first_din", first_din, 32'h24010005);
    check("nom_mem0", mem[0], 32'h24010005);
    check("nom_mem1", mem[1], 32'h00221821);
    check("nom_last_addr", last_addr, 1);
    check("nom_words", words_loaded, 2);
    @(negedge clk);
    check("nom_in_ready_after", in_ready, 0);
    check("nom_done_sticky", done, 1);

    // Bad checksum
    do_reset();
    mem[0] = 32'h0; mem[1] = 32'h0;
    for (int i = 0; i < 10; i++) send(nom[i], 0);
    send(8'h78, 0);
    check("bad_err", err, 1);
    check("bad_done", done, 0);
    check("bad_cpu_rst", cpu_rst, 1);
    check("bad_wr_count", wr_n - wr_base, 2);
    check("bad_mem1", mem[1], 32'h00221821);
    @(negedge clk);
    check("bad_in_ready", in_ready, 0);

    // Empty image
    do_reset();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check("empty_done", done, 1);
    check("empty_err", err, 0);
    check("empty_wr_count", wr_n - wr_base, 0);
    check("empty_words", words_loaded, 0);

    // Oversize count 0x0401 = 1025
    do_reset();
    send(8'h04, 0); send(8'h01, 0);
    check("over_err", err, 1);
    check("over_done", done, 0);
    check("over_cpu_rst", cpu_rst, 1);
    @(negedge clk);
    check("over_in_ready", in_ready, 0);
    check("over_wr_count", wr_n - wr_base, 0);

    // Gaps between bytes
    do_reset();
    mem[0] = 32'h0; mem[1] = 32'h0;
    for (int i = 0; i < 11; i++) send(nom[i], int'($urandom_range(0, 5)));
    check("gap_done", done, 1);
    check("gap_wr_count", wr_n - wr_base, 2);
    check("gap_mem0", mem[0], 32'h24010005);
    check("gap_mem1", mem[1], 32'h00221821);
    check("gap_words", words_loaded, 2);

    // Reset mid-load, asserted while the first write strobe is high
    do_reset();
    for (int i = 0; i < 6; i++) send(nom[i], 0);
    check("mid_we_before", im_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we", im_we, 0);
    check("mid_rst_addr", im_addr, 0);
    check("mid_rst_din", im_din, 0);
    check("mid_rst_words", words_loaded, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_cpu_rst", cpu_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_base = wr_n;
    mem[0] = 32'h0; mem[1] = 32'h0;
    for (int i = 0; i < 11; i++) send(nom[i], 0);
    check("mid_replay_done", done, 1);
    check("mid_replay_mem0", mem[0], 32'h24010005);
    check("mid_replay_mem1", mem[1], 32'h00221821);

    // Full image: 1024 words of 0xA5000000 + i
    do_reset();
    sum = 8'h04 + 8'h00;
    send(8'h04, 0); send(8'h00, 0);
    for (int i = 0; i < MAX_WORDS; i++) begin
      w = 32'hA500_0000 + 32'(i);
      for (int k = 3; k >= 0; k--) begin
        sum = sum + w[k*8 +: 8];
        send(w[k*8 +: 8], 0);
      end
    end
    check("full_done_before_csum", done, 0);
    send(8'h00 - sum, 0);
    check("full_done", done, 1);
    check("full_err", err, 0);
    check("full_wr_count", wr_n - wr_base, MAX_WORDS);
    check("full_last_addr", last_addr, MAX_WORDS - 1);
    check("full_words", words_loaded, MAX_WORDS);
    check("full_mem0", mem[0], 32'hA500_0000);
    check("full_mem1023", mem[1023], 32'hA500_03FF);
    check("full_mem517", mem[517], 32'hA500_0205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
